vending_machine_param: RTL and testbench
========================================

# vending_machine_param

Parametrised next-generation vending controller: configurable slot grid, stock depth, price width and timeout, with a run-time programmable per-slot price table. Accepts a card, a two-key (row, column) selection and a bank approval, then vends and waits for a door open/close cycle. It is the top-level control FSM of the vending design, driven directly by the keypad, card reader, bank link and door sensor.

## Interface
- N_ROWS, 2, number of rows (first code digit), 1..10
- N_COLS, 10, number of columns (second code digit), 1..10
- STOCK_W, 4, stock counter width per slot
- RELOAD_QTY, 10, stock loaded into every slot on RELOAD; saturates at 2^STOCK_W-1
- COST_W, 3, price width
- TIMEOUT_CYC, 5, idle cycles allowed in CODE1/CODE2/TRANSACT/VENDING, >=1
- SLOT_W (localparam), clog2(N_ROWS*N_COLS)

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- RELOAD  in  1  restock request
- CARD_IN  in  1  card inserted
- ITEM_CODE  in  4  keypad digit, sampled with KEY_PRESS
- KEY_PRESS  in  1  one-cycle key strobe
- VALID_TRAN  in  1  bank approval
- DOOR_OPEN  in  1  delivery door sensor
- PRICE_WE  in  1  price table write strobe
- PRICE_ADDR  in  SLOT_W  slot index written
- PRICE_DATA  in  COST_W  price value
- VEND  out  1  item released
- INVALID_SEL  out  1  rejected selection pulse
- COST  out  COST_W  price of current selection
- FAILED_TRAN  out  1  bank timeout pulse
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RELOADING, CODE1, CODE2, TRANSACT, VENDING. All outputs registered.
- Slot index = row*N_COLS + col. Per-slot stock counters (STOCK_W) and price registers (COST_W).
- RESET_N low: state IDLE; all stock 0; all prices 0; timer 0; VEND, INVALID_SEL, FAILED_TRAN, BUSY, COST all 0. Asserting mid-transaction aborts without decrementing.
- IDLE: RELOAD -> RELOADING (RELOAD wins over CARD_IN); else CARD_IN -> CODE1. PRICE_WE writes price table only in IDLE; ignored elsewhere. PRICE_ADDR >= N_ROWS*N_COLS ignored.
- RELOADING: all stock <= min(RELOAD_QTY, 2^STOCK_W-1); -> IDLE after one cycle.
- CODE1: KEY_PRESS with ITEM_CODE < N_ROWS latches row, -> CODE2; ITEM_CODE >= N_ROWS -> INVALID_SEL pulse, -> IDLE.
- CODE2: KEY_PRESS latches col. Reject (INVALID_SEL, -> IDLE) if col >= N_COLS, slot stock == 0, or slot price == 0. Otherwise COST <= price, -> TRANSACT.
- TRANSACT: VALID_TRAN -> VENDING and decrement selected slot stock exactly once. Timeout -> FAILED_TRAN pulse, -> IDLE.
- VENDING: VEND = 1. Door-opened flag set when DOOR_OPEN = 1. DOOR_OPEN = 0 with flag set -> IDLE (door cycled). Timeout applies only while the flag is clear; once opened, waits indefinitely for close.
- Timeout silently returns CODE1/CODE2 to IDLE.
- COST holds from CODE2 acceptance through VENDING; cleared to 0 on entry to IDLE.
- Stock never underflows (zero stock rejected in CODE2); stock never exceeds saturation.

## Timing
- All inputs sampled on the rising CLK edge; state and outputs update on the same edge.
- CARD_IN sampled at edge k: BUSY = 1 and state CODE1 from edge k.
- Invalid key at edge k: INVALID_SEL = 1 for the single cycle following edge k; state IDLE at edge k.
- Valid second key at edge k: COST valid after edge k.
- VALID_TRAN at edge k: VEND = 1 after edge k; stock decrement visible after edge k.
- Door-close detection at edge k: VEND = 0 and state IDLE after edge k.
- Timer clears on every state change and counts each cycle without a qualifying event. The state is exited at the TIMEOUT_CYC-th edge after entry (TIMEOUT_CYC = 5: entry at edge k, exit at edge k+5).
- FAILED_TRAN is a one-cycle pulse coincident with the return to IDLE.
- KEY_PRESS and timeout on the same edge: the key wins.
- VALID_TRAN and timeout on the same edge: VALID_TRAN wins.

## Test plan
- Reset, RELOAD, PRICE_WE slot 5 = 2, card, keys 0,5, VALID_TRAN -> COST = 2, VEND = 1, slot 5 stock 10 -> 9; DOOR_OPEN 1 then 0 -> IDLE, VEND = 0.
- Card, first key 7 with N_ROWS = 2 -> INVALID_SEL for exactly 1 cycle, BUSY = 0 next cycle; no stock change.
- Keys for unreloaded slot (stock 0), or reloaded slot with price 0 -> INVALID_SEL, COST remains 0.
- Valid selection, no VALID_TRAN -> FAILED_TRAN pulse exactly 5 cycles after TRANSACT entry; stock unchanged.
- VENDING with door opened at cycle 3 and held 20 cycles -> VEND stays 1 until close, then IDLE. Separately: door never opened -> IDLE after 5 cycles, stock still decremented once.
- RESET_N asserted asynchronously mid-VENDING -> VEND = 0 immediately, all stock 0; RELOAD with CARD_IN same cycle -> RELOADING. Repeat with N_ROWS = 3, N_COLS = 4, RELOAD_QTY = 20, STOCK_W = 4 -> stock saturates at 15; slot (2,3) index 11 vends.

Source files
------------

// File: rtl/vending_machine_param_if.sv
// ---------------------------------------------------------------------------
// vending_machine_param_if
//
// Bundles the peripheral-facing signals of the vending controller.
// The keypad, card reader, bank link, door sensor and price-programming
// inputs travel on this interface, together with the registered status
// outputs.
//
// Modports:
//   master - the environment side. It drives the requests and observes status.
//   slave  - the controller side. It receives the requests and drives status.
//
// Signals:
//   RELOAD      restock request
//   CARD_IN     card inserted
//   ITEM_CODE   keypad digit (4 bits), qualified by KEY_PRESS
//   KEY_PRESS   one-cycle key strobe
//   VALID_TRAN  bank approval
//   DOOR_OPEN   delivery door sensor
//   PRICE_WE    price table write strobe
//   PRICE_ADDR  slot index to write (SLOT_W bits)
//   PRICE_DATA  price value (COST_W bits)
//   VEND        item released
//   INVALID_SEL rejected selection pulse
//   COST        price of the current selection
//   FAILED_TRAN bank timeout pulse
//   BUSY        controller not idle
// ---------------------------------------------------------------------------
interface vending_machine_param_if #(
    parameter int SLOT_W = 5,
    parameter int COST_W = 3
);
    logic              RELOAD;
    logic              CARD_IN;
    logic [3:0]        ITEM_CODE;
    logic              KEY_PRESS;
    logic              VALID_TRAN;
    logic              DOOR_OPEN;
    logic              PRICE_WE;
    logic [SLOT_W-1:0] PRICE_ADDR;
    logic [COST_W-1:0] PRICE_DATA;
    logic              VEND;
    logic              INVALID_SEL;
    logic [COST_W-1:0] COST;
    logic              FAILED_TRAN;
    logic              BUSY;

    modport master (
        output RELOAD, CARD_IN, ITEM_CODE, KEY_PRESS, VALID_TRAN, DOOR_OPEN,
               PRICE_WE, PRICE_ADDR, PRICE_DATA,
        input  VEND, INVALID_SEL, COST, FAILED_TRAN, BUSY
    );

    modport slave (
        input  RELOAD, CARD_IN, ITEM_CODE, KEY_PRESS, VALID_TRAN, DOOR_OPEN,
               PRICE_WE, PRICE_ADDR, PRICE_DATA,
        output VEND, INVALID_SEL, COST, FAILED_TRAN, BUSY
    );
endinterface

// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//
// This is the top-level control FSM of a vending machine. The slot grid,
// stock depth, price width and timeout are parameters. Each slot has a stock
// counter and a price register. The price table can be reprogrammed while
// the machine is idle.
//
// A transaction proceeds as follows:
//   1. A card is inserted.
//   2. The user presses the row key, then the column key.
//   3. The bank approves the transaction.
//   4. The item is vended. The controller then waits for the delivery door
//      to open and close.
//
// Ports:
//   CLK      rising-edge clock
//   RESET_N  asynchronous active-low reset
//   bus      vending_machine_param_if.slave (request inputs, status outputs)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module vending_machine_param #(
    parameter int  N_ROWS      = 2,
    parameter int  N_COLS      = 10,
    parameter int  STOCK_W     = 4,
    parameter int  RELOAD_QTY  = 10,
    parameter int  COST_W      = 3,
    parameter int  TIMEOUT_CYC = 5,
    localparam int N_SLOTS     = N_ROWS * N_COLS,
    localparam int SLOT_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    vending_machine_param_if.slave   bus
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int STOCK_MAX = (1 << STOCK_W) - 1;

    // The reload quantity is clamped to what a stock counter can hold.
    localparam logic [STOCK_W-1:0] RELOAD_VAL =
        STOCK_W'((RELOAD_QTY > STOCK_MAX) ? STOCK_MAX : RELOAD_QTY);

    // Keypad digits are 4 bits wide. Row and column counts are at most 10,
    // so both limits fit in 4 bits.
    localparam logic [3:0]        ROW_LIMIT = 4'(N_ROWS);
    localparam logic [3:0]        COL_LIMIT = 4'(N_COLS);
    localparam logic [SLOT_W-1:0] COLS_S    = SLOT_W'(N_COLS);

    // The timer counts from 0 after entering a state. The exit edge is the
    // one at which the timer already holds TIMEOUT_CYC-1.
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RELOADING,
        ST_CODE1,
        ST_CODE2,
        ST_TRANSACT,
        ST_VENDING
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                           state_q, state_d;
    logic [TMR_W-1:0]                 timer_q, timer_d;
    logic [SLOT_W-1:0]                row_q, row_d;
    logic [SLOT_W-1:0]                slot_q, slot_d;
    logic                             door_seen_q, door_seen_d;
    logic [COST_W-1:0]                cost_q, cost_d;
    logic                             vend_q, vend_d;
    logic                             invalid_q, invalid_d;
    logic                             failed_q, failed_d;
    logic                             busy_q, busy_d;
    logic [N_SLOTS-1:0][STOCK_W-1:0]  stock_q, stock_d;
    logic [N_SLOTS-1:0][COST_W-1:0]   price_q, price_d;

    // Strobes from the FSM into the per-slot datapath.
    logic                             reload_en;
    logic                             dec_en;
    logic                             price_we_en;

    // -----------------------------------------------------------------------
    // Selection lookup for the second key
    // -----------------------------------------------------------------------
    logic                             col_ok;
    logic [SLOT_W-1:0]                sel_col;
    logic [SLOT_W-1:0]                sel_idx;
    logic [STOCK_W-1:0]               sel_stock;
    logic [COST_W-1:0]                sel_price;
    logic                             sel_ok;
    logic                             timeout;

    assign col_ok  = (bus.ITEM_CODE < COL_LIMIT);
    assign sel_col = SLOT_W'(bus.ITEM_CODE);

    // The index is forced to 0 when the column is out of range.
    // This keeps the table reads inside the array.
    // The selection is rejected anyway in that case.
    assign sel_idx   = col_ok ? (row_q * COLS_S + sel_col) : '0;
    assign sel_stock = stock_q[sel_idx];
    assign sel_price = price_q[sel_idx];
    assign sel_ok    = col_ok && (sel_stock != '0) && (sel_price != '0);

    assign timeout   = (timer_q == TMR_LAST);

    // -----------------------------------------------------------------------
    // Per-slot stock counters and price registers
    // -----------------------------------------------------------------------
    // Reload takes priority over the decrement.
    // The decrement only happens on slots that were checked to be non-zero
    // when the selection was accepted, so the counter cannot underflow.
    //
    // The price write matches the address against each slot index.
    // An address beyond the last slot therefore writes nothing.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
        assign stock_d[gi] =
            reload_en                              ? RELOAD_VAL :
            (dec_en && (slot_q == SLOT_W'(gi)))    ? stock_q[gi] - STOCK_W'(1) :
                                                     stock_q[gi];

        assign price_d[gi] =
            (price_we_en && (bus.PRICE_ADDR == SLOT_W'(gi))) ? bus.PRICE_DATA :
                                                               price_q[gi];
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        row_d       = row_q;
        slot_d      = slot_q;
        door_seen_d = door_seen_q;
        cost_d      = cost_q;
        invalid_d   = 1'b0;
        failed_d    = 1'b0;
        reload_en   = 1'b0;
        dec_en      = 1'b0;
        price_we_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d     = '0;
                door_seen_d = 1'b0;
                price_we_en = bus.PRICE_WE;
                if (bus.RELOAD) begin
                    state_d = ST_RELOADING;
                end else if (bus.CARD_IN) begin
                    state_d = ST_CODE1;
                end
            end

            ST_RELOADING: begin
                reload_en = 1'b1;
                state_d   = ST_IDLE;
            end

            ST_CODE1: begin
                // A key press on the timeout edge takes priority over the
                // timeout.
                if (bus.KEY_PRESS) begin
                    if (bus.ITEM_CODE < ROW_LIMIT) begin
                        row_d   = SLOT_W'(bus.ITEM_CODE);
                        state_d = ST_CODE2;
                    end else begin
                        invalid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_CODE2: begin
                if (bus.KEY_PRESS) begin
                    if (sel_ok) begin
                        slot_d  = sel_idx;
                        cost_d  = sel_price;
                        state_d = ST_TRANSACT;
                    end else begin
                        invalid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_TRANSACT: begin
                // Bank approval on the timeout edge takes priority over the
                // timeout.
                if (bus.VALID_TRAN) begin
                    dec_en      = 1'b1;
                    door_seen_d = 1'b0;
                    state_d     = ST_VENDING;
                end else if (timeout) begin
                    failed_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_VENDING: begin
                // Once the door has been seen open, the timeout is disabled.
                // The controller then waits as long as needed for the
                // door to close.
                if (door_seen_q) begin
                    if (!bus.DOOR_OPEN) begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.DOOR_OPEN) begin
                    door_seen_d = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state change restarts the timer.
        if (state_d != state_q) begin
            timer_d = '0;
        end

        // The displayed price is cleared whenever the controller returns to
        // idle.
        if (state_d == ST_IDLE) begin
            cost_d = '0;
        end
    end

    // The registered outputs follow the state being entered.
    // This lets them change on the same edge as the state.
    assign vend_d = (state_d == ST_VENDING);
    assign busy_d = (state_d != ST_IDLE);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            row_q       <= '0;
            slot_q      <= '0;
            door_seen_q <= 1'b0;
            cost_q      <= '0;
            vend_q      <= 1'b0;
            invalid_q   <= 1'b0;
            failed_q    <= 1'b0;
            busy_q      <= 1'b0;
            stock_q     <= '0;
            price_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            row_q       <= row_d;
            slot_q      <= slot_d;
            door_seen_q <= door_seen_d;
            cost_q      <= cost_d;
            vend_q      <= vend_d;
            invalid_q   <= invalid_d;
            failed_q    <= failed_d;
            busy_q      <= busy_d;
            stock_q     <= stock_d;
            price_q     <= price_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.VEND        = vend_q;
    assign bus.INVALID_SEL = invalid_q;
    assign bus.COST        = cost_q;
    assign bus.FAILED_TRAN = failed_q;
    assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_param
//
// Directed testbench for vending_machine_param. It instantiates two
// controllers:
//   dut_a  default geometry: 2x10 slots, reload 10
//   dut_b  3x4 slots, reload 20, which saturates at 15 with 4-bit stock
//
// Inputs are driven 1 time unit after a rising edge.
// Outputs are checked 1 time unit after the edge that should produce them.
// ---------------------------------------------------------------------------
module tb_vending_machine_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    vending_machine_param_if #(.SLOT_W(5), .COST_W(3)) if_a ();
    vending_machine_param_if #(.SLOT_W(4), .COST_W(3)) if_b ();

    vending_machine_param #(
        .N_ROWS(2), .N_COLS(10), .STOCK_W(4), .RELOAD_QTY(10),
        .COST_W(3), .TIMEOUT_CYC(5)
    ) dut_a (
        .CLK(clk), .RESET_N(rst_n), .bus(if_a.slave)
    );

    vending_machine_param #(
        .N_ROWS(3), .N_COLS(4), .STOCK_W(4), .RELOAD_QTY(20),
        .COST_W(3), .TIMEOUT_CYC(5)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n), .bus(if_b.slave)
    );

    // -----------------------------------------------------------------------
    // Stimulus helpers (drive only, no checking)
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_a.RELOAD = 0; if_a.CARD_IN = 0; if_a.ITEM_CODE = 0; if_a.KEY_PRESS = 0;
        if_a.VALID_TRAN = 0; if_a.DOOR_OPEN = 0; if_a.PRICE_WE = 0;
        if_a.PRICE_ADDR = 0; if_a.PRICE_DATA = 0;
        if_b.RELOAD = 0; if_b.CARD_IN = 0; if_b.ITEM_CODE = 0; if_b.KEY_PRESS = 0;
        if_b.VALID_TRAN = 0; if_b.DOOR_OPEN = 0; if_b.PRICE_WE = 0;
        if_b.PRICE_ADDR = 0; if_b.PRICE_DATA = 0;
    endtask

    task automatic card_a();
        if_a.CARD_IN = 1; step(); if_a.CARD_IN = 0;
    endtask

    task automatic key_a(input logic [3:0] code);
        if_a.ITEM_CODE = code; if_a.KEY_PRESS = 1; step(); if_a.KEY_PRESS = 0;
    endtask

    task automatic card_b();
        if_b.CARD_IN = 1; step(); if_b.CARD_IN = 0;
    endtask

    task automatic key_b(input logic [3:0] code);
        if_b.ITEM_CODE = code; if_b.KEY_PRESS = 1; step(); if_b.KEY_PRESS = 0;
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) step();
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        total_cnt++; if (if_a.VEND !== 1'b0) $display("FAIL reset_vend: got %b want 0", if_a.VEND); else pass_cnt++;
        total_cnt++; if (if_a.COST !== 3'd0) $display("FAIL reset_cost: got %0d want 0", if_a.COST); else pass_cnt++;
        total_cnt++; if (if_a.INVALID_SEL !== 1'b0) $display("FAIL reset_invalid: got %b want 0", if_a.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (if_a.FAILED_TRAN !== 1'b0) $display("FAIL reset_failed: got %b want 0", if_a.FAILED_TRAN); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd0) $display("FAIL reset_stock: got %0d want 0", dut_a.stock_q[5]); else pass_cnt++;
        total_cnt++; if (if_b.BUSY !== 1'b0) $display("FAIL reset_busy_b: got %b want 0", if_b.BUSY); else pass_cnt++;
        rst_n = 1;
        step();
        $display("txn reset: done");
    endtask

    task automatic test_basic_vend();
        if_a.RELOAD = 1; step(); if_a.RELOAD = 0;
        total_cnt++; if (if_a.BUSY !== 1'b1) $display("FAIL reload_busy: got %b want 1", if_a.BUSY); else pass_cnt++;
        step();
        total_cnt++; if (dut_a.stock_q[5] !== 4'd10) $display("FAIL reload_stock: got %0d want 10", dut_a.stock_q[5]); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL reload_idle: got %b want 0", if_a.BUSY); else pass_cnt++;
        if_a.PRICE_WE = 1; if_a.PRICE_ADDR = 5'd5; if_a.PRICE_DATA = 3'd2; step(); if_a.PRICE_WE = 0;
        card_a();
        total_cnt++; if (if_a.BUSY !== 1'b1) $display("FAIL card_busy: got %b want 1", if_a.BUSY); else pass_cnt++;
        key_a(4'd0);
        key_a(4'd5);
        total_cnt++; if (if_a.COST !== 3'd2) $display("FAIL sel_cost: got %0d want 2", if_a.COST); else pass_cnt++;
        total_cnt++; if (if_a.VEND !== 1'b0) $display("FAIL sel_vend: got %b want 0", if_a.VEND); else pass_cnt++;
        if_a.VALID_TRAN = 1; step(); if_a.VALID_TRAN = 0;
        total_cnt++; if (if_a.VEND !== 1'b1) $display("FAIL approve_vend: got %b want 1", if_a.VEND); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd9) $display("FAIL approve_stock: got %0d want 9", dut_a.stock_q[5]); else pass_cnt++;
        if_a.DOOR_OPEN = 1; step();
        total_cnt++; if (if_a.VEND !== 1'b1) $display("FAIL door_open_vend: got %b want 1", if_a.VEND); else pass_cnt++;
        if_a.DOOR_OPEN = 0; step();
        total_cnt++; if (if_a.VEND !== 1'b0) $display("FAIL door_close_vend: got %b want 0", if_a.VEND); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL door_close_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        total_cnt++; if (if_a.COST !== 3'd0) $display("FAIL door_close_cost: got %0d want 0", if_a.COST); else pass_cnt++;
        $display("txn basic_vend: slot 5 price 2 vended");
    endtask

    task automatic test_invalid_row();
        card_a();
        key_a(4'd7);
        total_cnt++; if (if_a.INVALID_SEL !== 1'b1) $display("FAIL badrow_pulse: got %b want 1", if_a.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL badrow_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        step();
        total_cnt++; if (if_a.INVALID_SEL !== 1'b0) $display("FAIL badrow_pulse_end: got %b want 0", if_a.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd9) $display("FAIL badrow_stock: got %0d want 9", dut_a.stock_q[5]); else pass_cnt++;
        $display("txn invalid_row: key 7 rejected");
    endtask

    task automatic test_reject_selection();
        card_a(); key_a(4'd0); key_a(4'd3);
        total_cnt++; if (if_a.INVALID_SEL !== 1'b1) $display("FAIL zero_price_pulse: got %b want 1", if_a.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (if_a.COST !== 3'd0) $display("FAIL zero_price_cost: got %0d want 0", if_a.COST); else pass_cnt++;
        card_a(); key_a(4'd1); key_a(4'd12);
        total_cnt++; if (if_a.INVALID_SEL !== 1'b1) $display("FAIL bad_col_pulse: got %b want 1", if_a.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL bad_col_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        $display("txn reject_selection: zero price and bad column rejected");
    endtask

    task automatic test_key_at_timeout();
        card_a();
        repeat (4) step();
        key_a(4'd1);
        total_cnt++; if (if_a.BUSY !== 1'b1) $display("FAIL key_beats_timeout: got busy %b want 1", if_a.BUSY); else pass_cnt++;
        repeat (4) step();
        total_cnt++; if (if_a.BUSY !== 1'b1) $display("FAIL code2_early_exit: got busy %b want 1", if_a.BUSY); else pass_cnt++;
        step();
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL code2_timeout: got busy %b want 0", if_a.BUSY); else pass_cnt++;
        total_cnt++; if (if_a.FAILED_TRAN !== 1'b0) $display("FAIL code2_timeout_failed: got %b want 0", if_a.FAILED_TRAN); else pass_cnt++;
        $display("txn key_at_timeout: key accepted on timeout edge, code2 timed out silently");
    endtask

    task automatic test_transact_timeout();
        card_a(); key_a(4'd0); key_a(4'd5);
        for (int i = 1; i <= 4; i++) begin
            step();
            total_cnt++; if (if_a.FAILED_TRAN !== 1'b0 || if_a.BUSY !== 1'b1)
                $display("FAIL bank_wait_%0d: got failed %b busy %b want failed 0 busy 1", i, if_a.FAILED_TRAN, if_a.BUSY);
            else pass_cnt++;
        end
        step();
        total_cnt++; if (if_a.FAILED_TRAN !== 1'b1) $display("FAIL bank_timeout_pulse: got %b want 1", if_a.FAILED_TRAN); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL bank_timeout_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        step();
        total_cnt++; if (if_a.FAILED_TRAN !== 1'b0) $display("FAIL bank_timeout_pulse_end: got %b want 0", if_a.FAILED_TRAN); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd9) $display("FAIL bank_timeout_stock: got %0d want 9", dut_a.stock_q[5]); else pass_cnt++;
        $display("txn transact_timeout: bank timeout after 5 cycles");
    endtask

    task automatic test_door_held();
        card_a(); key_a(4'd0); key_a(4'd5);
        if_a.VALID_TRAN = 1; step(); if_a.VALID_TRAN = 0;
        repeat (2) step();
        if_a.DOOR_OPEN = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            total_cnt++; if (if_a.VEND !== 1'b1) $display("FAIL door_held_vend_%0d: got %b want 1", i, if_a.VEND); else pass_cnt++;
        end
        if_a.DOOR_OPEN = 0; step();
        total_cnt++; if (if_a.VEND !== 1'b0 || if_a.BUSY !== 1'b0)
            $display("FAIL door_held_close: got vend %b busy %b want 0 0", if_a.VEND, if_a.BUSY);
        else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd8) $display("FAIL door_held_stock: got %0d want 8", dut_a.stock_q[5]); else pass_cnt++;
        $display("txn door_held: door held 20 cycles then closed");
    endtask

    task automatic test_no_door();
        card_a(); key_a(4'd0); key_a(4'd5);
        if_a.VALID_TRAN = 1; step(); if_a.VALID_TRAN = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total_cnt++; if (if_a.VEND !== 1'b1) $display("FAIL no_door_vend_%0d: got %b want 1", i, if_a.VEND); else pass_cnt++;
        end
        step();
        total_cnt++; if (if_a.VEND !== 1'b0 || if_a.BUSY !== 1'b0)
            $display("FAIL no_door_timeout: got vend %b busy %b want 0 0", if_a.VEND, if_a.BUSY);
        else pass_cnt++;
        total_cnt++; if (if_a.FAILED_TRAN !== 1'b0) $display("FAIL no_door_failed: got %b want 0", if_a.FAILED_TRAN); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd7) $display("FAIL no_door_stock: got %0d want 7", dut_a.stock_q[5]); else pass_cnt++;
        $display("txn no_door: vend timed out, stock decremented once");
    endtask

    task automatic test_reset_midvend();
        card_a(); key_a(4'd0); key_a(4'd5);
        if_a.VALID_TRAN = 1; step(); if_a.VALID_TRAN = 0;
        step();
        #3 rst_n = 0;
        #1;
        total_cnt++; if (if_a.VEND !== 1'b0) $display("FAIL async_reset_vend: got %b want 0", if_a.VEND); else pass_cnt++;
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", if_a.BUSY); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd0) $display("FAIL async_reset_stock: got %0d want 0", dut_a.stock_q[5]); else pass_cnt++;
        step();
        rst_n = 1;
        step();
        if_a.RELOAD = 1; if_a.CARD_IN = 1; step(); if_a.RELOAD = 0; if_a.CARD_IN = 0;
        total_cnt++; if (if_a.BUSY !== 1'b1) $display("FAIL reload_vs_card_busy: got %b want 1", if_a.BUSY); else pass_cnt++;
        step();
        total_cnt++; if (if_a.BUSY !== 1'b0) $display("FAIL reload_wins: got busy %b want 0", if_a.BUSY); else pass_cnt++;
        total_cnt++; if (dut_a.stock_q[5] !== 4'd10) $display("FAIL reload_wins_stock: got %0d want 10", dut_a.stock_q[5]); else pass_cnt++;
        $display("txn reset_midvend: async abort, reload beats card");
    endtask

    task automatic test_param_b();
        if_b.PRICE_WE = 1; if_b.PRICE_ADDR = 4'd11; if_b.PRICE_DATA = 3'd3; step(); if_b.PRICE_WE = 0;
        card_b(); key_b(4'd2); key_b(4'd3);
        total_cnt++; if (if_b.INVALID_SEL !== 1'b1) $display("FAIL b_zero_stock_pulse: got %b want 1", if_b.INVALID_SEL); else pass_cnt++;
        total_cnt++; if (if_b.COST !== 3'd0) $display("FAIL b_zero_stock_cost: got %0d want 0", if_b.COST); else pass_cnt++;
        card_b(); key_b(4'd3);
        total_cnt++; if (if_b.INVALID_SEL !== 1'b1) $display("FAIL b_bad_row: got %b want 1", if_b.INVALID_SEL); else pass_cnt++;
        if_b.RELOAD = 1; step(); if_b.RELOAD = 0; step();
        total_cnt++; if (dut_b.stock_q[11] !== 4'd15) $display("FAIL b_saturate_11: got %0d want 15", dut_b.stock_q[11]); else pass_cnt++;
        total_cnt++; if (dut_b.stock_q[0] !== 4'd15) $display("FAIL b_saturate_0: got %0d want 15", dut_b.stock_q[0]); else pass_cnt++;
        card_b(); key_b(4'd2); key_b(4'd3);
        total_cnt++; if (if_b.COST !== 3'd3) $display("FAIL b_cost: got %0d want 3", if_b.COST); else pass_cnt++;
        if_b.VALID_TRAN = 1; step(); if_b.VALID_TRAN = 0;
        total_cnt++; if (if_b.VEND !== 1'b1) $display("FAIL b_vend: got %b want 1", if_b.VEND); else pass_cnt++;
        total_cnt++; if (dut_b.stock_q[11] !== 4'd14) $display("FAIL b_stock_dec: got %0d want 14", dut_b.stock_q[11]); else pass_cnt++;
        if_b.DOOR_OPEN = 1; step(); if_b.DOOR_OPEN = 0; step();
        total_cnt++; if (if_b.VEND !== 1'b0 || if_b.BUSY !== 1'b0)
            $display("FAIL b_door_cycle: got vend %b busy %b want 0 0", if_b.VEND, if_b.BUSY);
        else pass_cnt++;
        $display("txn param_b: 3x4 grid, saturated reload, slot 11 vended");
    endtask

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_vend();
        test_invalid_row();
        test_reject_selection();
        test_key_at_timeout();
        test_transact_timeout();
        test_door_held();
        test_no_door();
        test_reset_midvend();
        test_param_b();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
